// File: rtl/climate_ctrl_mz_if.sv
`default_nettype none
// ============================================================================
//  Module      : climate_ctrl_mz_if
//  Description : Sensor-side and actuator-side signal bundle for the
//                climate_ctrl_mz thermostat controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface climate_ctrl_mz_if #(
    parameter int SENSOR_W = 8,
    parameter int FAN_W    = 4
);
    logic                       enable;
    logic signed [SENSOR_W-1:0] sensor;
    logic                       sensor_valid;
    logic                       heater;
    logic                       cooler;
    logic        [FAN_W-1:0]    fan_rps;
    logic        [1:0]          mode;
    logic                       fault;

    // Sensor front-end / supervisor side: supplies samples, observes actuators
    modport master (
        output enable,
        output sensor,
        output sensor_valid,
        input  heater,
        input  cooler,
        input  fan_rps,
        input  mode,
        input  fault
    );

    // Controller side
    modport slave (
        input  enable,
        input  sensor,
        input  sensor_valid,
        output heater,
        output cooler,
        output fan_rps,
        output mode,
        output fault
    );
endinterface
`default_nettype wire

// File: rtl/climate_ctrl_mz.sv
`default_nettype none
// ============================================================================
//  Module      : climate_ctrl_mz
//  Description : Thermostat controller. Signed temperature samples select
//                IDLE/HEAT/COOL with hysteresis and a minimum mode dwell,
//                choose a three-level fan target while cooling, ramp the fan
//                speed toward that target, and lock out on repeated
//                out-of-range samples (FAULT).
//  Revision    : 1.0 - initial release
// ============================================================================
module climate_ctrl_mz #(
    parameter int SENSOR_W  = 8,
    parameter int FAN_W     = 4,
    parameter int HEAT_ON   = 15,
    parameter int HEAT_OFF  = 30,
    parameter int COOL_ON   = 35,
    parameter int COOL_OFF  = 25,
    parameter int FAN_LO    = 4,
    parameter int FAN_MID   = 6,
    parameter int FAN_HI    = 8,
    parameter int LO_UP     = 40,
    parameter int MID_DN    = 35,
    parameter int MID_UP    = 45,
    parameter int HI_DN     = 40,
    parameter int MIN_DWELL = 4,
    parameter int RAMP_DIV  = 2,
    parameter int SENSE_MIN = -40,
    parameter int SENSE_MAX = 100,
    parameter int FAULT_CNT = 3
) (
    input  logic              clk,
    input  logic              reset,
    climate_ctrl_mz_if.slave  bus_if
);

    localparam int c_dwell_w = $clog2(MIN_DWELL + 1);
    localparam int c_ramp_w  = $clog2(RAMP_DIV + 1);
    localparam int c_fcnt_w  = $clog2(FAULT_CNT + 1);

    localparam logic signed [SENSOR_W-1:0] c_heat_on   = SENSOR_W'(HEAT_ON);
    localparam logic signed [SENSOR_W-1:0] c_heat_off  = SENSOR_W'(HEAT_OFF);
    localparam logic signed [SENSOR_W-1:0] c_cool_on   = SENSOR_W'(COOL_ON);
    localparam logic signed [SENSOR_W-1:0] c_cool_off  = SENSOR_W'(COOL_OFF);
    localparam logic signed [SENSOR_W-1:0] c_lo_up     = SENSOR_W'(LO_UP);
    localparam logic signed [SENSOR_W-1:0] c_mid_dn    = SENSOR_W'(MID_DN);
    localparam logic signed [SENSOR_W-1:0] c_mid_up    = SENSOR_W'(MID_UP);
    localparam logic signed [SENSOR_W-1:0] c_hi_dn     = SENSOR_W'(HI_DN);
    localparam logic signed [SENSOR_W-1:0] c_sense_min = SENSOR_W'(SENSE_MIN);
    localparam logic signed [SENSOR_W-1:0] c_sense_max = SENSOR_W'(SENSE_MAX);

    localparam logic [FAN_W-1:0]     c_fan_lo    = FAN_W'(FAN_LO);
    localparam logic [FAN_W-1:0]     c_fan_mid   = FAN_W'(FAN_MID);
    localparam logic [FAN_W-1:0]     c_fan_hi    = FAN_W'(FAN_HI);
    localparam logic [FAN_W-1:0]     c_fan_one   = FAN_W'(1);
    localparam logic [c_dwell_w-1:0] c_min_dwell = c_dwell_w'(MIN_DWELL);
    localparam logic [c_dwell_w-1:0] c_dwell_one = c_dwell_w'(1);
    localparam logic [c_ramp_w-1:0]  c_ramp_last = c_ramp_w'(RAMP_DIV - 1);
    localparam logic [c_ramp_w-1:0]  c_ramp_one  = c_ramp_w'(1);
    localparam logic [c_fcnt_w-1:0]  c_fault_cnt = c_fcnt_w'(FAULT_CNT);
    localparam logic [c_fcnt_w-1:0]  c_fcnt_one  = c_fcnt_w'(1);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_HEAT  = 2'd1,
        MODE_COOL  = 2'd2,
        MODE_FAULT = 2'd3
    } mode_e;

    mode_e                 mode_q,    mode_d;
    logic [FAN_W-1:0]      fan_tgt_q, fan_tgt_d;
    logic [FAN_W-1:0]      fan_rps_q, fan_rps_d;
    logic [c_dwell_w-1:0]  dwell_q,   dwell_d;
    logic [c_ramp_w-1:0]   ramp_q,    ramp_d;
    logic [c_fcnt_w-1:0]   bad_q,     bad_d;
    logic [c_fcnt_w-1:0]   good_q,    good_d;
    logic                  heater_q;
    logic                  cooler_q;
    logic                  fault_q;

    logic signed [SENSOR_W-1:0] w_sample;
    logic                       w_in_range;
    logic                       w_good_sample;
    logic                       w_dwell_done;

    assign w_sample      = bus_if.sensor;
    assign w_in_range    = (w_sample >= c_sense_min) && (w_sample <= c_sense_max);
    assign w_good_sample = bus_if.sensor_valid && w_in_range;
    assign w_dwell_done  = (dwell_q == c_min_dwell);

    // Register all state and the decoded actuator outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_IDLE;
            fan_tgt_q <= '0;
            fan_rps_q <= '0;
            dwell_q   <= '0;
            ramp_q    <= '0;
            bad_q     <= '0;
            good_q    <= '0;
            heater_q  <= 1'b0;
            cooler_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            fan_tgt_q <= fan_tgt_d;
            fan_rps_q <= fan_rps_d;
            dwell_q   <= dwell_d;
            ramp_q    <= ramp_d;
            bad_q     <= bad_d;
            good_q    <= good_d;
            heater_q  <= (mode_d == MODE_HEAT);
            cooler_q  <= (mode_d == MODE_COOL);
            fault_q   <= (mode_d == MODE_FAULT);
        end
    end

    // Next-state: fan ramp, fault qualification, mode/fan-band transitions, dwell
    always_comb begin
        mode_d    = mode_q;
        fan_tgt_d = fan_tgt_q;
        fan_rps_d = fan_rps_q;
        dwell_d   = dwell_q;
        ramp_d    = ramp_q;
        bad_d     = bad_q;
        good_d    = good_q;

        // The ramp chases the registered target, independent of mode logic;
        // a mid-ramp target change keeps the partial ramp count.
        if (fan_rps_q != fan_tgt_q) begin
            if (ramp_q == c_ramp_last) begin
                ramp_d    = '0;
                fan_rps_d = (fan_rps_q < fan_tgt_q) ? (fan_rps_q + c_fan_one)
                                                    : (fan_rps_q - c_fan_one);
            end else begin
                ramp_d = ramp_q + c_ramp_one;
            end
        end else begin
            ramp_d = '0;
        end

        if (!bus_if.enable) begin
            // Fault counters deliberately hold while disabled
            mode_d    = MODE_IDLE;
            fan_tgt_d = '0;
        end else begin
            if (bus_if.sensor_valid) begin
                if (!w_in_range) begin
                    if (bad_q != c_fault_cnt) begin
                        bad_d = bad_q + c_fcnt_one;
                    end
                    good_d = '0;
                end else begin
                    bad_d = '0;
                    if ((mode_q == MODE_FAULT) && (good_q != c_fault_cnt)) begin
                        good_d = good_q + c_fcnt_one;
                    end
                end
            end

            if ((mode_q != MODE_FAULT) && (bad_d == c_fault_cnt)) begin
                mode_d    = MODE_FAULT;
                fan_tgt_d = '0;
                good_d    = '0;
            end else if (mode_q == MODE_FAULT) begin
                if (good_d == c_fault_cnt) begin
                    mode_d    = MODE_IDLE;
                    fan_tgt_d = '0;
                    good_d    = '0;
                end
            end else if (w_good_sample) begin
                case (mode_q)
                    MODE_IDLE: begin
                        if (w_dwell_done) begin
                            if (w_sample > c_cool_on) begin
                                mode_d    = MODE_COOL;
                                fan_tgt_d = c_fan_lo;
                            end else if (w_sample < c_heat_on) begin
                                mode_d = MODE_HEAT;
                            end
                        end
                    end
                    MODE_HEAT: begin
                        if (w_dwell_done && (w_sample > c_heat_off)) begin
                            mode_d = MODE_IDLE;
                        end
                    end
                    MODE_COOL: begin
                        // A dwell-blocked exit request suppresses band steps too
                        if ((fan_tgt_q == c_fan_lo) && (w_sample < c_cool_off)) begin
                            if (w_dwell_done) begin
                                mode_d    = MODE_IDLE;
                                fan_tgt_d = '0;
                            end
                        end else if (fan_tgt_q == c_fan_lo) begin
                            if (w_sample > c_lo_up) begin
                                fan_tgt_d = c_fan_mid;
                            end
                        end else if (fan_tgt_q == c_fan_mid) begin
                            if (w_sample < c_mid_dn) begin
                                fan_tgt_d = c_fan_lo;
                            end else if (w_sample > c_mid_up) begin
                                fan_tgt_d = c_fan_hi;
                            end
                        end else if (fan_tgt_q == c_fan_hi) begin
                            if (w_sample < c_hi_dn) begin
                                fan_tgt_d = c_fan_mid;
                            end
                        end
                    end
                    default: begin
                        mode_d = mode_q;
                    end
                endcase
            end
        end

        // Dwell restarts on any mode change or while disabled, else saturates
        if (!bus_if.enable || (mode_d != mode_q)) begin
            dwell_d = '0;
        end else if (!w_dwell_done) begin
            dwell_d = dwell_q + c_dwell_one;
        end
    end

    assign bus_if.heater  = heater_q;
    assign bus_if.cooler  = cooler_q;
    assign bus_if.fan_rps = fan_rps_q;
    assign bus_if.mode    = mode_q;
    assign bus_if.fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_climate_ctrl_mz.sv
`default_nettype none
// ============================================================================
//  Module      : tb_climate_ctrl_mz
//  Description : Directed self-checking bench for climate_ctrl_mz.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_climate_ctrl_mz;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    climate_ctrl_mz_if #(.SENSOR_W(8), .FAN_W(4)) bus ();

    climate_ctrl_mz dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input int s, input bit v);
        bus.enable       = en;
        bus.sensor       = 8'(s);
        bus.sensor_valid = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int md, input int ht, input int cl,
                           input int fn, input int flt);
        chk({tag, ".mode"},   32'(bus.mode),    32'(md));
        chk({tag, ".heater"}, 32'(bus.heater),  32'(ht));
        chk({tag, ".cooler"}, 32'(bus.cooler),  32'(cl));
        chk({tag, ".fan"},    32'(bus.fan_rps), 32'(fn));
        chk({tag, ".fault"},  32'(bus.fault),   32'(flt));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // 1: reset with a hot sample present, then dwell-gated entry into COOL
        reset = 1'b1;
        drive(1, 50, 1);
        tick(2);
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick(4);
        chk("dwell_idle.mode", 32'(bus.mode), 0);
        tick(1);
        chk_all("enter_cool", 2, 0, 1, 0, 0);
        drive(1, 38, 1);
        tick(1);
        chk("ramp_c1.fan", 32'(bus.fan_rps), 0);
        tick(1);
        chk("ramp_c2.fan", 32'(bus.fan_rps), 1);
        tick(5);
        chk("ramp_c7.fan", 32'(bus.fan_rps), 3);
        tick(1);
        chk("ramp_c8.fan", 32'(bus.fan_rps), 4);

        // 2: fan band steps LO->MID->HI->MID->LO, then exit to IDLE
        drive(1, 41, 1);
        tick(1);
        chk_all("lo_to_mid", 2, 0, 1, 4, 0);
        drive(1, 40, 1);
        tick(2);
        chk("mid_ramp1.fan", 32'(bus.fan_rps), 5);
        tick(2);
        chk("mid_ramp2.fan", 32'(bus.fan_rps), 6);
        drive(1, 46, 1);
        tick(1);
        drive(1, 42, 1);
        tick(2);
        chk("hi_ramp1.fan", 32'(bus.fan_rps), 7);
        tick(2);
        chk("hi_ramp2.fan", 32'(bus.fan_rps), 8);
        drive(1, 39, 1);
        tick(1);
        drive(1, 40, 1);
        tick(2);
        chk("hi_to_mid1.fan", 32'(bus.fan_rps), 7);
        tick(2);
        chk("hi_to_mid2.fan", 32'(bus.fan_rps), 6);
        drive(1, 34, 1);
        tick(1);
        drive(1, 38, 1);
        tick(4);
        chk("mid_to_lo.fan", 32'(bus.fan_rps), 4);
        drive(1, 24, 1);
        tick(1);
        chk_all("cool_exit", 0, 0, 0, 4, 0);

        // 3: HEAT entry gated by dwell, HEAT_OFF boundary
        drive(1, 10, 1);
        tick(4);
        chk("heat_dwell.mode", 32'(bus.mode), 0);
        tick(1);
        chk_all("enter_heat", 1, 1, 0, 2, 0);
        drive(1, 31, 1);
        tick(1);
        chk("heat_blocked.mode", 32'(bus.mode), 1);
        drive(1, 20, 1);
        tick(2);
        chk("fan_down.fan", 32'(bus.fan_rps), 0);
        tick(1);
        drive(1, 30, 1);
        tick(1);
        chk("heat_off_eq.mode", 32'(bus.mode), 1);
        drive(1, 31, 1);
        tick(1);
        chk_all("heat_exit", 0, 0, 0, 0, 0);

        // 4: fault entry from COOL, interrupted recovery, full recovery
        drive(1, 36, 1);
        tick(4);
        chk("cool_dwell.mode", 32'(bus.mode), 0);
        tick(1);
        chk("cool_again.mode", 32'(bus.mode), 2);
        drive(1, 120, 1);
        tick(2);
        chk_all("bad2", 2, 0, 1, 1, 0);
        tick(1);
        chk_all("fault_in", 3, 0, 0, 1, 1);
        drive(1, 20, 1);
        tick(1);
        chk("fault_fan.fan", 32'(bus.fan_rps), 0);
        tick(1);
        drive(1, 120, 1);
        tick(1);
        chk("fault_hold.mode", 32'(bus.mode), 3);
        drive(1, 20, 1);
        tick(2);
        chk("good2.mode", 32'(bus.mode), 3);
        tick(1);
        chk_all("fault_out", 0, 0, 0, 0, 0);

        // 5: invalid samples are ignored
        drive(1, -100, 0);
        tick(20);
        chk_all("invalid", 0, 0, 0, 0, 0);

        // 6: disable while cooling at full fan, then dwell-gated re-entry
        drive(1, 50, 1);
        tick(1);
        chk("cool3.mode", 32'(bus.mode), 2);
        tick(2);
        drive(1, 42, 1);
        tick(13);
        chk("full_ramp1.fan", 32'(bus.fan_rps), 7);
        tick(1);
        chk("full_ramp2.fan", 32'(bus.fan_rps), 8);
        drive(0, 42, 1);
        tick(1);
        chk_all("disable", 0, 0, 0, 8, 0);
        tick(15);
        chk("disable_ramp1.fan", 32'(bus.fan_rps), 1);
        tick(1);
        chk("disable_ramp2.fan", 32'(bus.fan_rps), 0);
        drive(1, 36, 1);
        tick(4);
        chk("reenable_dwell.mode", 32'(bus.mode), 0);
        tick(1);
        chk_all("reenable_cool", 2, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
